// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives loads/stores over a single-outstanding req/ack
// data bus, passes ALU results through, stalls upstream while a bus access
// is in flight, and flags misaligned accesses and bus timeouts.
module mem_access_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_memOp,
  input  logic [4:0]            i_regDest,
  input  logic                  i_writeEnable,
  input  logic [31:0]           i_result,
  input  logic [31:0]           i_storeData,
  output logic [4:0]            o_regDest,
  output logic                  o_writeEnable,
  output logic [31:0]           o_result,
  output logic                  stall,
  output logic                  alignErr,
  output logic                  busErr,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter spans 0..MAX_WAIT-1; the last value is the final WAIT cycle.
  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_waitCnt;
  logic [31:0]           r_rdata;
  logic                  r_alignErr;
  logic                  r_busErr;
  logic                  r_busReq;
  logic                  r_busWe;
  logic [ADDR_WIDTH-1:0] r_busAddr;
  logic [3:0]            r_busBe;
  logic [31:0]           r_busWdata;

  logic                  w_isLoad;
  logic                  w_isStore;
  logic                  w_isMem;
  logic                  w_misaligned;
  logic [1:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_loadVal;

  assign w_off  = i_result[1:0];
  assign w_addr = ADDR_WIDTH'(i_result);

  assign alignErr  = r_alignErr;
  assign busErr    = r_busErr;
  assign bus_req   = r_busReq;
  assign bus_we    = r_busWe;
  assign bus_addr  = r_busAddr;
  assign bus_be    = r_busBe;
  assign bus_wdata = r_busWdata;

  // Decode the op class and alignment requirement.
  always_comb begin
    w_isLoad     = 1'b0;
    w_isStore    = 1'b0;
    w_misaligned = 1'b0;
    case (i_memOp)
      OP_LB, OP_LBU: w_isLoad = 1'b1;
      OP_LH, OP_LHU: begin
        w_isLoad     = 1'b1;
        w_misaligned = w_off[0];
      end
      OP_LW: begin
        w_isLoad     = 1'b1;
        w_misaligned = (w_off != 2'b00);
      end
      OP_SB: w_isStore = 1'b1;
      OP_SH: begin
        w_isStore    = 1'b1;
        w_misaligned = w_off[0];
      end
      OP_SW: begin
        w_isStore    = 1'b1;
        w_misaligned = (w_off != 2'b00);
      end
      default: ;
    endcase
    w_isMem = w_isLoad | w_isStore;
  end

  // Big-endian lane selection and replication for store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    case (i_memOp)
      OP_SB: begin
        w_be    = 4'b1000 >> w_off;
        w_wdata = {4{i_storeData[7:0]}};
      end
      OP_SH: begin
        w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{i_storeData[15:0]}};
      end
      OP_SW: begin
        w_be    = 4'b1111;
        w_wdata = i_storeData;
      end
      default: ;
    endcase
  end

  // Big-endian extraction and sign/zero extension of captured load data.
  always_comb begin
    case (w_off)
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = w_off[1] ? r_rdata[15:0] : r_rdata[31:16];
    case (i_memOp)
      OP_LB:   w_loadVal = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_loadVal = {24'd0, w_byte};
      OP_LH:   w_loadVal = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_loadVal = {16'd0, w_half};
      default: w_loadVal = r_rdata;
    endcase
  end

  // Stage outputs toward MEM_WB and the upstream stall.
  always_comb begin
    o_regDest     = i_regDest;
    o_result      = i_result;
    o_writeEnable = i_writeEnable;
    stall         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_isMem) begin
          o_writeEnable = 1'b0;
          stall         = ~w_misaligned;
        end
      end
      S_WAIT: begin
        o_writeEnable = 1'b0;
        stall         = 1'b1;
      end
      S_DONE: begin
        if (w_isLoad) begin
          o_result      = w_loadVal;
          o_writeEnable = i_writeEnable & ~r_busErr;
        end else begin
          o_writeEnable = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Bus transaction FSM, wait counter, read capture and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_waitCnt  <= '0;
      r_rdata    <= '0;
      r_alignErr <= 1'b0;
      r_busErr   <= 1'b0;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busBe    <= '0;
      r_busWdata <= '0;
    end else begin
      r_alignErr <= 1'b0;
      r_busErr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_isMem && w_misaligned) begin
            r_alignErr <= 1'b1;
          end else if (w_isMem) begin
            r_state    <= S_WAIT;
            r_waitCnt  <= '0;
            r_busReq   <= 1'b1;
            r_busWe    <= w_isStore;
            r_busAddr  <= w_addr & ~(ADDR_WIDTH'(3));
            r_busBe    <= w_be;
            r_busWdata <= w_wdata;
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            r_rdata  <= bus_rdata;
            r_busReq <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_waitCnt == CNT_LAST) begin
            r_busReq <= 1'b0;
            r_busErr <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected
// results, bus requests and error pulses; monitors pop and compare.
module tb_mem_access_stage;

  localparam int unsigned AW = 32;
  localparam int unsigned MW = 4;

  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3,
                         LHU = 4'd4, LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    i_memOp;
  logic [4:0]    i_regDest;
  logic          i_writeEnable;
  logic [31:0]   i_result;
  logic [31:0]   i_storeData;
  logic [4:0]    o_regDest;
  logic          o_writeEnable;
  logic [31:0]   o_result;
  logic          stall;
  logic          alignErr;
  logic          busErr;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_memOp(i_memOp), .i_regDest(i_regDest), .i_writeEnable(i_writeEnable),
    .i_result(i_result), .i_storeData(i_storeData),
    .o_regDest(o_regDest), .o_writeEnable(o_writeEnable), .o_result(o_result),
    .stall(stall), .alignErr(alignErr), .busErr(busErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        we;
    logic        chk_res;
  } res_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic align;
    logic bus;
  } err_t;

  res_t res_q[$];
  bus_t bus_q[$];
  err_t err_q[$];

  int   checks = 0;
  int   errors = 0;
  logic tb_valid = 1'b0;
  logic prev_req = 1'b0;
  bus_t cur_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_res(input logic [31:0] r, input logic [4:0] d, input logic we, input logic chk);
    res_t e;
    e.result = r; e.dest = d; e.we = we; e.chk_res = chk;
    res_q.push_back(e);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    bus_t e;
    e.addr = a; e.we = we; e.be = be; e.wdata = wd;
    bus_q.push_back(e);
  endtask

  task automatic push_err(input logic a, input logic b);
    err_t e;
    e.align = a; e.bus = b;
    err_q.push_back(e);
  endtask

  // Result monitor: every non-stalled cycle of a tracked op is a completion.
  always @(negedge clk) begin : res_mon
    res_t e;
    if (!rst && tb_valid && !stall) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = res_q.pop_front();
        if (e.chk_res) check("o_result", o_result, e.result);
        check("o_regDest", {27'd0, o_regDest}, {27'd0, e.dest});
        check("o_writeEnable", {31'd0, o_writeEnable}, {31'd0, e.we});
      end
    end
  end

  // Bus monitor: new requests are popped; held requests must stay stable.
  always @(negedge clk) begin : bus_mon
    bus_t e;
    if (bus_req === 1'b1 && !prev_req) begin
      if (bus_q.size() == 0) begin
        check("unexpected_bus_req", 32'd1, 32'd0);
      end else begin
        e = bus_q.pop_front();
        check("bus_addr", bus_addr, e.addr);
        check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
        check("bus_be", {28'd0, bus_be}, {28'd0, e.be});
        if (e.we) check("bus_wdata", bus_wdata, e.wdata);
      end
      cur_bus.addr = bus_addr; cur_bus.we = bus_we; cur_bus.be = bus_be; cur_bus.wdata = bus_wdata;
    end else if (bus_req === 1'b1 && prev_req) begin
      check("bus_held", {bus_addr[30:0], bus_we}, {cur_bus.addr[30:0], cur_bus.we});
      check("bus_held_be_wd", bus_wdata ^ {28'd0, bus_be}, cur_bus.wdata ^ {28'd0, cur_bus.be});
    end
    prev_req = (bus_req === 1'b1);
  end

  // Error monitor: each alignErr/busErr pulse must be expected.
  always @(negedge clk) begin : err_mon
    err_t e;
    if (alignErr === 1'b1 || busErr === 1'b1) begin
      if (err_q.size() == 0) begin
        check("unexpected_err", {30'd0, alignErr, busErr}, 32'd0);
      end else begin
        e = err_q.pop_front();
        check("err_flags", {30'd0, alignErr, busErr}, {30'd0, e.align, e.bus});
      end
    end
  end

  // Drives one op, acks on the ack_after-th WAIT cycle (0 = never), counts stall cycles.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] dest, input logic we, input int ack_after,
                       input logic [31:0] rdata, input int exp_stall);
    int  waits  = 0;
    int  stalls = 0;
    int  budget = 0;
    bit  done   = 0;
    @(posedge clk); #1;
    i_memOp = op; i_result = addr; i_storeData = sdata;
    i_regDest = dest; i_writeEnable = we; tb_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!stall) begin
        done = 1;
      end else begin
        stalls++;
        if (bus_req) begin
          waits++;
          if (waits == ack_after) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
          end
        end
      end
      budget++;
      if (!done && budget > 100) begin
        check("op_completion_budget", 32'd1, 32'd0);
        done = 1;
      end
    end
    check("stall_cycles", stalls, exp_stall);
    @(posedge clk); #1;
    tb_valid = 1'b0; i_memOp = NONE; i_writeEnable = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; i_memOp = NONE; i_regDest = '0; i_writeEnable = 1'b0;
    i_result = '0; i_storeData = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_errs", {30'd0, alignErr, busErr}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Passthrough: NONE and an invalid op code
    push_res(32'h0000_1234, 5'd5, 1'b1, 1'b1);
    do_op(NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0, 0);
    push_res(32'hCAFE_0001, 5'd7, 1'b1, 1'b1);
    do_op(4'd12, 32'hCAFE_0001, 32'h0, 5'd7, 1'b1, 0, 32'h0, 0);

    // Loads with extension
    push_bus(32'h100, 1'b0, 4'hF, 32'h0);
    push_res(32'hFFFF_FF80, 5'd3, 1'b1, 1'b1);
    do_op(LB, 32'h101, 32'h0, 5'd3, 1'b1, 3, 32'h1180_2233, 4);
    push_bus(32'h100, 1'b0, 4'hF, 32'h0);
    push_res(32'h0000_0080, 5'd3, 1'b1, 1'b1);
    do_op(LBU, 32'h101, 32'h0, 5'd3, 1'b1, 3, 32'h1180_2233, 4);
    push_bus(32'h100, 1'b0, 4'hF, 32'h0);
    push_res(32'hFFFF_8765, 5'd10, 1'b1, 1'b1);
    do_op(LH, 32'h102, 32'h0, 5'd10, 1'b1, 1, 32'h1234_8765, 2);
    push_bus(32'h100, 1'b0, 4'hF, 32'h0);
    push_res(32'h0000_9ABC, 5'd11, 1'b1, 1'b1);
    do_op(LHU, 32'h100, 32'h0, 5'd11, 1'b1, 1, 32'h9ABC_0001, 2);
    push_bus(32'h104, 1'b0, 4'hF, 32'h0);
    push_res(32'hDEAD_BEEF, 5'd12, 1'b1, 1'b1);
    do_op(LW, 32'h104, 32'h0, 5'd12, 1'b1, 2, 32'hDEAD_BEEF, 3);

    // Stores: lanes and replication
    push_bus(32'h200, 1'b1, 4'b0011, 32'hBEEF_BEEF);
    push_res(32'h202, 5'd9, 1'b0, 1'b1);
    do_op(SH, 32'h202, 32'hAAAA_BEEF, 5'd9, 1'b1, 1, 32'h0, 2);
    push_bus(32'h200, 1'b1, 4'b1100, 32'h1357_1357);
    push_res(32'h200, 5'd9, 1'b0, 1'b1);
    do_op(SH, 32'h200, 32'h0000_1357, 5'd9, 1'b1, 1, 32'h0, 2);
    push_bus(32'h300, 1'b1, 4'b0001, 32'h7878_7878);
    push_res(32'h303, 5'd1, 1'b0, 1'b1);
    do_op(SB, 32'h303, 32'h1234_5678, 5'd1, 1'b1, 1, 32'h0, 2);
    push_bus(32'h300, 1'b1, 4'b1000, 32'hA5A5_A5A5);
    push_res(32'h300, 5'd1, 1'b0, 1'b1);
    do_op(SB, 32'h300, 32'h0000_00A5, 5'd1, 1'b1, 2, 32'h0, 3);
    push_bus(32'h500, 1'b1, 4'b1111, 32'hCAFE_F00D);
    push_res(32'h500, 5'd8, 1'b0, 1'b1);
    do_op(SW, 32'h500, 32'hCAFE_F00D, 5'd8, 1'b1, 1, 32'h0, 2);

    // Misaligned accesses: no bus request, no stall, write suppressed
    push_res(32'h103, 5'd4, 1'b0, 1'b1);
    push_err(1'b1, 1'b0);
    do_op(LW, 32'h103, 32'h0, 5'd4, 1'b1, 0, 32'h0, 0);
    push_res(32'h201, 5'd4, 1'b0, 1'b1);
    push_err(1'b1, 1'b0);
    do_op(SH, 32'h201, 32'h1111_2222, 5'd4, 1'b1, 0, 32'h0, 0);

    // Timeout after MAX_WAIT WAIT cycles
    push_bus(32'h400, 1'b0, 4'hF, 32'h0);
    push_err(1'b0, 1'b1);
    push_res(32'h0, 5'd6, 1'b0, 1'b0);
    do_op(LW, 32'h400, 32'h0, 5'd6, 1'b1, 0, 32'h0, MW + 1);

    // Reset in the second WAIT cycle, late ack ignored
    push_bus(32'h600, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    i_memOp = LW; i_result = 32'h600; i_regDest = 5'd2; i_writeEnable = 1'b1;
    @(posedge clk); #1;
    check("req_wait1", {31'd0, bus_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("req_after_rst", {31'd0, bus_req}, 32'd0);
    rst = 1'b0; i_memOp = NONE; i_writeEnable = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    check("idle_after_rst", {31'd0, stall}, 32'd0);
    check("we_after_rst", {31'd0, o_writeEnable}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("req_after_late_ack", {31'd0, bus_req}, 32'd0);
    check("stall_after_late_ack", {31'd0, stall}, 32'd0);
    check("errs_after_late_ack", {30'd0, alignErr, busErr}, 32'd0);

    // Normal load after the abandoned one
    push_bus(32'h604, 1'b0, 4'hF, 32'h0);
    push_res(32'h0102_0304, 5'd2, 1'b1, 1'b1);
    do_op(LW, 32'h604, 32'h0, 5'd2, 1'b1, 1, 32'h0102_0304, 2);

    repeat (3) @(posedge clk);
    #1;
    check("res_q_drained", res_q.size(), 32'd0);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
